// File: rtl/sub_8_serial.sv
// sub_8_serial: bit-serial subtractor, d = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop process the captured operands
// over WIDTH cycles. The ALU multicycle controller uses it for SUB and CMP.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, honoured only in IDLE or DONE
//   a      in   minuend (captured on accept)
//   b      in   subtrahend (captured on accept)
//   bin    in   borrow-in (captured on accept)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when d and flags update
//   d      out  difference, modulo 2^WIDTH
//   bout   out  borrow-out (unsigned a < b + bin)
//   zero   out  d == 0
//   ovf    out  signed overflow
module sub_8_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CW-1:0]    count;

    logic             ai;
    logic             bi;
    logic             di;
    logic             br_nx;
    logic [WIDTH-1:0] d_nx;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] fsub(input logic x, input logic y, input logic c);
        logic diff;
        logic bo;
        diff = x ^ y ^ c;
        bo   = (~x & y) | (~(x ^ y) & c);
        return {bo, diff};
    endfunction

    always_comb begin
        ai          = a_w[count];
        bi          = b_w[count];
        {br_nx, di} = fsub(ai, bi, br);
        // Result enters at the MSB and moves down, so bit i ends at position i
        // after WIDTH shifts.
        d_nx        = {di, d_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_w   <= '0;
            b_w   <= '0;
            d_sr  <= '0;
            br    <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_w   <= a;
                        b_w   <= b;
                        br    <= bin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    d_sr  <= d_nx;
                    br    <= br_nx;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        // Last bit: publish result and flags together.
                        d     <= d_nx;
                        bout  <= br_nx;
                        zero  <= (d_nx == '0);
                        ovf   <= (a_w[WIDTH-1] != b_w[WIDTH-1]) &&
                                 (d_nx[WIDTH-1] != a_w[WIDTH-1]);
                        count <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_8_serial.sv
// Testbench for sub_8_serial: directed vectors with hand-computed results.
// Stimulus pushes expected {d,bout,zero,ovf} into a queue on each accept edge;
// a separate monitor pops and compares whenever done is seen.
module tb_sub_8_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
    logic       zero;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    logic [10:0] expq[$];

    sub_8_serial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [10:0] e;
                e = expq.pop_front();
                check("result{d,bout,zero,ovf}", 32'({d, bout, zero, ovf}), 32'(e));
            end
        end
    end

    // Issue one operation, then watch busy/done for the WIDTH cycles that follow.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [10:0] exp);
        start = 1'b1; a = ta; b = tb; bin = tbin;
        @(posedge clk);
        expq.push_back(exp);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check("busy_during_op", 32'(busy), (k < 8) ? 32'd1 : 32'd0);
            check("done_timing",    32'(done), (k == 8) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        check("reset_outputs", 32'({busy, done, d, bout, zero, ovf}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // {d, bout, zero, ovf}
        do_op(8'h5A, 8'h23, 1'b0, {8'h37, 1'b0, 1'b0, 1'b0});
        do_op(8'h10, 8'h20, 1'b0, {8'hF0, 1'b1, 1'b0, 1'b0});
        do_op(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b0, 1'b1});
        do_op(8'h7F, 8'hFF, 1'b0, {8'h80, 1'b1, 1'b0, 1'b1});
        do_op(8'h42, 8'h42, 1'b0, {8'h00, 1'b0, 1'b1, 1'b0});
        do_op(8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 1'b0, 1'b0});
        check("hold_d_after_done", 32'(d), 32'hFF);

        // Back-to-back with start held high; operands change after each accept.
        start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
        @(posedge clk);
        expq.push_back({8'h02, 1'b0, 1'b0, 1'b0});
        #1; a = 8'h0C; b = 8'h04;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk);
            if (k == 9)  expq.push_back({8'h08, 1'b0, 1'b0, 1'b0});
            if (k == 18) expq.push_back({8'hFF, 1'b1, 1'b0, 1'b0});
            #1;
            if (k == 9)  begin a = 8'h01; b = 8'h02; end
            if (k == 18) begin start = 1'b0; a = 8'h33; b = 8'h11; end
            check("b2b_done_pulse", 32'(done),
                  (k == 8 || k == 17 || k == 26) ? 32'd1 : 32'd0);
            if (k == 1 || k == 10 || k == 19)
                check("b2b_busy_rise", 32'(busy), 32'd1);
        end

        // Reset in the middle of an operation.
        start = 1'b1; a = 8'h5A; b = 8'h23; bin = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy, done, d, bout, zero, ovf}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_no_done", 32'({busy, done}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h09, 8'h04, 1'b0, {8'h05, 1'b0, 1'b0, 1'b0});

        // Idle with random inputs and no start.
        for (int k = 0; k < 20; k++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            check("idle_hold", 32'({busy, done, d, bout, zero, ovf}),
                  32'({1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0}));
        end

        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
